// File: rtl/trig_time_gen_if.sv
// Timestamp bus from the trigger time generator to the address FIFO / event buffer.
interface trig_time_gen_if;
    logic [15:0] trig_time_o;
    logic        trig_time_valid_o;
    logic [1:0]  trig_src_o;

    modport master (output trig_time_o, output trig_time_valid_o, output trig_src_o);
    modport slave  (input  trig_time_o, input  trig_time_valid_o, input  trig_src_o);
endinterface

// File: rtl/trig_time_gen.sv
// Trigger acceptance, holdoff and timestamp generation with outstanding-event
// back-pressure and a saturating dropped-trigger counter.
module trig_time_gen #(
    parameter int unsigned NEVT_MAX = 4,
    parameter logic [15:0] OFFSET   = 16'd0
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              run_rst_i,
    input  logic              run_stop_i,
    input  logic              rf_trig_i,
    input  logic              sw_trig_i,
    input  logic [1:0]        trig_mask_i,
    input  logic [15:0]       holdoff_i,
    input  logic              evt_done_i,
    trig_time_gen_if.master   tt_if,
    output logic              busy_o,
    output logic [2:0]        outstanding_o,
    output logic [15:0]       dropped_o
);

    localparam logic [2:0] NEVT_MAX_C = 3'(NEVT_MAX);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t      state_r;
    logic [15:0] time_cnt_r;
    logic [15:0] hold_cnt_r;

    logic [1:0]  src_s;
    logic        pend_s;
    logic        accept_s;
    logic        reject_s;
    logic [2:0]  outst_nxt_s;

    // Trigger qualification and next outstanding count.
    always_comb begin
        src_s       = {sw_trig_i & ~trig_mask_i[1], rf_trig_i & ~trig_mask_i[0]};
        pend_s      = |src_s;
        accept_s    = 1'b0;
        reject_s    = 1'b0;
        outst_nxt_s = outstanding_o;
        // Run control pulses take precedence over a trigger in the same cycle.
        if (pend_s && (state_r == ST_ARMED) && !run_rst_i && !run_stop_i) begin
            accept_s = (outstanding_o != NEVT_MAX_C);
            reject_s = (outstanding_o == NEVT_MAX_C);
        end else begin
            accept_s = 1'b0;
            reject_s = 1'b0;
        end
        case ({accept_s, evt_done_i})
            2'b10:   outst_nxt_s = outstanding_o + 3'd1;
            2'b01: begin
                if (outstanding_o != 3'd0) begin
                    outst_nxt_s = outstanding_o - 3'd1;
                end else begin
                    outst_nxt_s = outstanding_o;
                end
            end
            default: outst_nxt_s = outstanding_o;
        endcase
    end

    // Time base, run FSM, holdoff timer, counters and registered outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r                 <= ST_STOPPED;
            time_cnt_r              <= 16'd0;
            hold_cnt_r              <= 16'd0;
            outstanding_o           <= 3'd0;
            busy_o                  <= 1'b0;
            dropped_o               <= 16'd0;
            tt_if.trig_time_o       <= 16'd0;
            tt_if.trig_time_valid_o <= 1'b0;
            tt_if.trig_src_o        <= 2'd0;
        end else begin
            time_cnt_r              <= run_rst_i ? 16'd0 : time_cnt_r + 16'd1;
            tt_if.trig_time_valid_o <= accept_s;
            if (accept_s) begin
                tt_if.trig_time_o <= time_cnt_r - OFFSET;
                tt_if.trig_src_o  <= src_s;
            end

            if (run_rst_i) begin
                outstanding_o <= 3'd0;
                busy_o        <= 1'b0;
                dropped_o     <= 16'd0;
            end else begin
                outstanding_o <= outst_nxt_s;
                busy_o        <= (outst_nxt_s == NEVT_MAX_C);
                if (reject_s && (dropped_o != 16'hFFFF)) begin
                    dropped_o <= dropped_o + 16'd1;
                end
            end

            if (run_stop_i) begin
                state_r    <= ST_STOPPED;
                hold_cnt_r <= 16'd0;
            end else if (run_rst_i) begin
                state_r    <= ST_ARMED;
                hold_cnt_r <= 16'd0;
            end else begin
                case (state_r)
                    ST_STOPPED: state_r <= ST_STOPPED;
                    ST_ARMED: begin
                        // Zero holdoff keeps the block armed for the very next cycle.
                        if (accept_s && (holdoff_i != 16'd0)) begin
                            state_r    <= ST_HOLDOFF;
                            hold_cnt_r <= holdoff_i;
                        end
                    end
                    ST_HOLDOFF: begin
                        // Counter reaches 0 on this edge, so the next cycle is armed again.
                        if (hold_cnt_r <= 16'd1) begin
                            state_r    <= ST_ARMED;
                            hold_cnt_r <= 16'd0;
                        end else begin
                            hold_cnt_r <= hold_cnt_r - 16'd1;
                        end
                    end
                    default: begin
                        state_r    <= ST_STOPPED;
                        hold_cnt_r <= 16'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trig_time_gen.sv
// Scoreboard bench for trig_time_gen: expected strobes are queued when a trigger
// is driven and checked by a negedge monitor when the DUT strobes.
module tb_trig_time_gen;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        run_rst_i, run_stop_i, rf_trig_i, sw_trig_i, evt_done_i;
    logic [1:0]  trig_mask_i;
    logic [15:0] holdoff_i;
    logic        busy_o, busy2;
    logic [2:0]  outstanding_o, outst2;
    logic [15:0] dropped_o, dropped2;

    trig_time_gen_if tt_if ();
    trig_time_gen_if tt_if2 ();

    always #5 aclk = ~aclk;

    trig_time_gen #(.NEVT_MAX(4), .OFFSET(16'd0)) dut (
        .aclk(aclk), .aresetn(aresetn), .run_rst_i(run_rst_i), .run_stop_i(run_stop_i),
        .rf_trig_i(rf_trig_i), .sw_trig_i(sw_trig_i), .trig_mask_i(trig_mask_i),
        .holdoff_i(holdoff_i), .evt_done_i(evt_done_i), .tt_if(tt_if),
        .busy_o(busy_o), .outstanding_o(outstanding_o), .dropped_o(dropped_o)
    );

    trig_time_gen #(.NEVT_MAX(4), .OFFSET(16'd100)) dut_off (
        .aclk(aclk), .aresetn(aresetn), .run_rst_i(run_rst_i), .run_stop_i(run_stop_i),
        .rf_trig_i(rf_trig_i), .sw_trig_i(sw_trig_i), .trig_mask_i(trig_mask_i),
        .holdoff_i(holdoff_i), .evt_done_i(evt_done_i), .tt_if(tt_if2),
        .busy_o(busy2), .outstanding_o(outst2), .dropped_o(dropped2)
    );

    typedef struct packed {
        logic [15:0] t;
        logic [1:0]  s;
    } exp_t;

    exp_t        exp_q[$];
    int          strobe_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc_cnt  = 0;
    logic [15:0] model_time;

    // Reference time base: counts every cycle, cleared by reset and run_rst_i.
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) model_time <= 16'd0;
        else if (run_rst_i) model_time <= 16'd0;
        else model_time <= model_time + 16'd1;
    end

    always @(posedge aclk) cyc_cnt <= cyc_cnt + 1;

    // Strobe monitor: every strobe must match the oldest queued expectation.
    always @(negedge aclk) begin
        if (aresetn && tt_if.trig_time_valid_o) begin
            strobe_q.push_back(cyc_cnt);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got time=%h src=%b, required no strobe",
                         tt_if.trig_time_o, tt_if.trig_src_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ({tt_if.trig_time_o, tt_if.trig_src_o} !== {mon_e.t, mon_e.s}) begin
                    n_fail++;
                    $display("FAIL strobe_value: got time=%h src=%b, required time=%h src=%b",
                             tt_if.trig_time_o, tt_if.trig_src_o, mon_e.t, mon_e.s);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge aclk);
    endtask

    // Drive one trigger cycle; queue the strobe the specification requires if accepted.
    task automatic fire(input logic r, input logic s, input logic d, input bit acc,
                        input logic [1:0] es);
        rf_trig_i  = r;
        sw_trig_i  = s;
        evt_done_i = d;
        if (acc) exp_q.push_back({model_time, es});
        @(negedge aclk);
        rf_trig_i  = 1'b0;
        sw_trig_i  = 1'b0;
        evt_done_i = 1'b0;
    endtask

    task automatic done_pulse();
        evt_done_i = 1'b1;
        @(negedge aclk);
        evt_done_i = 1'b0;
    endtask

    task automatic run_rst_pulse();
        run_rst_i = 1'b1;
        @(negedge aclk);
        run_rst_i = 1'b0;
    endtask

    task automatic test_reset();
        idle(2);
        n_checks++; if (tt_if.trig_time_o !== 16'd0) begin n_fail++; $display("FAIL rst_time: got %h, required 0", tt_if.trig_time_o); end
        n_checks++; if (tt_if.trig_time_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", tt_if.trig_time_valid_o); end
        n_checks++; if (tt_if.trig_src_o !== 2'd0) begin n_fail++; $display("FAIL rst_src: got %b, required 0", tt_if.trig_src_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy_o); end
        n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL rst_outst: got %0d, required 0", outstanding_o); end
        n_checks++; if (dropped_o !== 16'd0) begin n_fail++; $display("FAIL rst_dropped: got %0d, required 0", dropped_o); end
        aresetn = 1'b1;
        idle(2);
        fire(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        idle(2);
        n_checks++; if (dropped_o !== 16'd0) begin n_fail++; $display("FAIL stopped_dropped: got %0d, required 0", dropped_o); end
        n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL stopped_outst: got %0d, required 0", outstanding_o); end
    endtask

    task automatic test_timestamp();
        run_rst_pulse();
        for (int i = 0; i < 40 && model_time != 16'd10; i++) @(negedge aclk);
        n_checks++; if (model_time !== 16'd10) begin n_fail++; $display("FAIL wait_time10: got %0d, required 10", model_time); end
        fire(1'b1, 1'b0, 1'b0, 1'b1, 2'b01);
        n_checks++; if (outstanding_o !== 3'd1) begin n_fail++; $display("FAIL ts_outst: got %0d, required 1", outstanding_o); end
        idle(3);
        n_checks++; if (tt_if.trig_time_o !== 16'd10 || tt_if.trig_time_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL ts_hold: got time=%0d valid=%b, required time=10 valid=0", tt_if.trig_time_o, tt_if.trig_time_valid_o);
        end
    endtask

    task automatic test_holdoff();
        holdoff_i = 16'd5;
        done_pulse();
        n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL ho_drain: got %0d, required 0", outstanding_o); end
        strobe_q.delete();
        for (int k = 0; k < 13; k++) fire(1'b0, 1'b1, 1'b0, (k % 6) == 0, 2'b10);
        idle(8);
        n_checks++; if (strobe_q.size() != 3) begin n_fail++; $display("FAIL ho_count: got %0d strobes, required 3", strobe_q.size()); end
        else begin
            n_checks++; if (strobe_q[1] - strobe_q[0] != 6 || strobe_q[2] - strobe_q[1] != 6) begin
                n_fail++; $display("FAIL ho_spacing: got %0d,%0d cycles, required 6,6", strobe_q[1] - strobe_q[0], strobe_q[2] - strobe_q[1]);
            end
        end
        n_checks++; if (dropped_o !== 16'd0) begin n_fail++; $display("FAIL ho_dropped: got %0d, required 0", dropped_o); end
        repeat (3) done_pulse();
        done_pulse();
        n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL done_at_zero: got %0d, required 0", outstanding_o); end
    endtask

    task automatic test_full();
        holdoff_i = 16'd2;
        for (int i = 0; i < 5; i++) begin
            fire(1'b1, 1'b0, 1'b0, i < 4, 2'b01);
            idle(3);
        end
        n_checks++; if (outstanding_o !== 3'd4 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL full_state: got outst=%0d busy=%b, required 4/1", outstanding_o, busy_o);
        end
        n_checks++; if (dropped_o !== 16'd1) begin n_fail++; $display("FAIL full_dropped: got %0d, required 1", dropped_o); end
        done_pulse();
        n_checks++; if (outstanding_o !== 3'd3 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL full_release: got outst=%0d busy=%b, required 3/0", outstanding_o, busy_o);
        end
        fire(1'b1, 1'b0, 1'b0, 1'b1, 2'b01);
        n_checks++; if (outstanding_o !== 3'd4 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL full_refill: got outst=%0d busy=%b, required 4/1", outstanding_o, busy_o);
        end
        idle(3);
    endtask

    task automatic test_coincide();
        done_pulse();
        idle(3);
        fire(1'b1, 1'b0, 1'b1, 1'b1, 2'b01);
        n_checks++; if (outstanding_o !== 3'd3) begin n_fail++; $display("FAIL acc_and_done: got %0d, required 3", outstanding_o); end
        idle(3);
        fire(1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
        n_checks++; if (outstanding_o !== 3'd4) begin n_fail++; $display("FAIL both_src_outst: got %0d, required 4", outstanding_o); end
        repeat (4) done_pulse();
        idle(3);
        trig_mask_i = 2'b01;
        fire(1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
        idle(3);
        trig_mask_i = 2'b11;
        fire(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        idle(3);
        trig_mask_i = 2'b00;
        n_checks++; if (dropped_o !== 16'd1 || outstanding_o !== 3'd1) begin
            n_fail++; $display("FAIL mask_state: got dropped=%0d outst=%0d, required 1/1", dropped_o, outstanding_o);
        end
    endtask

    task automatic test_offset();
        run_rst_pulse();
        for (int i = 0; i < 80 && model_time != 16'd40; i++) @(negedge aclk);
        n_checks++; if (model_time !== 16'd40) begin n_fail++; $display("FAIL wait_time40: got %0d, required 40", model_time); end
        fire(1'b1, 1'b0, 1'b0, 1'b1, 2'b01);
        n_checks++; if (tt_if2.trig_time_valid_o !== 1'b1 || tt_if2.trig_time_o !== 16'hFFC4) begin
            n_fail++; $display("FAIL offset_wrap: got valid=%b time=%h, required 1/ffc4", tt_if2.trig_time_valid_o, tt_if2.trig_time_o);
        end
        n_checks++; if (outst2 !== 3'd1 || dropped2 !== 16'd0 || busy2 !== 1'b0) begin
            n_fail++; $display("FAIL offset_counts: got outst=%0d dropped=%0d busy=%b, required 1/0/0", outst2, dropped2, busy2);
        end
        idle(3);
    endtask

    task automatic test_reset_midholdoff();
        holdoff_i = 16'd20;
        fire(1'b1, 1'b0, 1'b0, 1'b1, 2'b01);
        idle(3);
        aresetn = 1'b0;
        #1;
        n_checks++; if (tt_if.trig_time_o !== 16'd0 || tt_if.trig_src_o !== 2'd0 || tt_if.trig_time_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL async_rst_bus: got time=%h src=%b valid=%b, required 0/0/0", tt_if.trig_time_o, tt_if.trig_src_o, tt_if.trig_time_valid_o);
        end
        n_checks++; if (outstanding_o !== 3'd0 || busy_o !== 1'b0 || dropped_o !== 16'd0) begin
            n_fail++; $display("FAIL async_rst_cnt: got outst=%0d busy=%b dropped=%0d, required 0/0/0", outstanding_o, busy_o, dropped_o);
        end
        @(negedge aclk);
        aresetn    = 1'b1;
        run_stop_i = 1'b1;
        run_rst_i  = 1'b1;
        @(negedge aclk);
        run_stop_i = 1'b0;
        run_rst_i  = 1'b0;
        n_checks++; if ({tt_if.trig_time_o, tt_if.trig_src_o, tt_if.trig_time_valid_o, busy_o, outstanding_o, dropped_o} !== 39'd0) begin
            n_fail++; $display("FAIL stop_rst_outputs: got time=%h src=%b valid=%b busy=%b outst=%0d dropped=%0d, required all 0",
                     tt_if.trig_time_o, tt_if.trig_src_o, tt_if.trig_time_valid_o, busy_o, outstanding_o, dropped_o);
        end
        for (int i = 0; i < 6; i++) begin
            fire(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
            idle(1);
        end
        n_checks++; if (dropped_o !== 16'd0 || outstanding_o !== 3'd0) begin
            n_fail++; $display("FAIL stopped_after_rst: got dropped=%0d outst=%0d, required 0/0", dropped_o, outstanding_o);
        end
    endtask

    initial begin
        aresetn     = 1'b0;
        run_rst_i   = 1'b0;
        run_stop_i  = 1'b0;
        rf_trig_i   = 1'b0;
        sw_trig_i   = 1'b0;
        evt_done_i  = 1'b0;
        trig_mask_i = 2'b00;
        holdoff_i   = 16'd0;
        test_reset();
        test_timestamp();
        test_holdoff();
        test_full();
        test_coincide();
        test_offset();
        test_reset_midholdoff();
        idle(2);
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL missing_strobe: got %0d unmatched expectations, required 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
